// File: rtl/axi4_pkg.sv
// Shared AXI4 burst/response types, FSM states and per-beat address helpers.
// Address math is done at a fixed 64-bit width; callers truncate to their own bus width.
package axi4_pkg;

    typedef enum logic [1:0] {FIXED = 2'd0, INCR = 2'd1, WRAP = 2'd2, RSVD = 2'd3} burst_t;
    typedef enum logic [1:0] {OKAY = 2'd0, EXOKAY = 2'd1, SLVERR = 2'd2, DECERR = 2'd3} resp_t;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

    localparam int ADDR_MAX_W = 64;
    typedef logic [ADDR_MAX_W-1:0] addr_max_t;
    localparam addr_max_t ONE = addr_max_t'(1);

    function automatic addr_max_t axi4_next_addr(input addr_max_t addr, input logic [2:0] size,
                                                 input logic [7:0] len, input burst_t burst);
        addr_max_t s, b, nxt;
        s = ONE << size;
        b = (addr_max_t'(len) + ONE) << size;
        case (burst)
            FIXED:   nxt = addr;
            WRAP:    nxt = (addr & ~(b - ONE)) | ((addr + s) & (b - ONE));
            default: nxt = (addr & ~(s - ONE)) + s;
        endcase
        return nxt;
    endfunction

    // Burst-type legality only; the size limit depends on the bus width and is checked by the caller.
    function automatic logic axi4_burst_legal(input addr_max_t addr, input logic [2:0] size,
                                              input logic [7:0] len, input burst_t burst);
        logic ok;
        ok = (burst != RSVD);
        if (burst == WRAP) begin
            if (!(len inside {8'd1, 8'd3, 8'd7, 8'd15})) ok = 1'b0;
            if ((addr & ((ONE << size) - ONE)) != '0)    ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Per-direction burst address/beat tracker: current beat on addr_o/last_o/burst_err_o and a
// same-cycle lookahead (nxt_*) of the state after load/advance, so reads can prefetch without a bubble.
module axi4_burst_addr_gen
    import axi4_pkg::*;
#(
    parameter int AW         = 8,
    parameter int DATA_BYTES = 4,
    parameter int MEM_WORDS  = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic          advance_i,
    input  logic [AW-1:0] addr_i,
    input  logic [7:0]    len_i,
    input  logic [2:0]    size_i,
    input  logic [1:0]    burst_i,
    output logic [AW-1:0] addr_o,
    output logic          last_o,
    output logic          burst_err_o,
    output logic [AW-1:0] nxt_addr_o,
    output logic          nxt_last_o,
    output logic          nxt_err_o
);
    localparam int          MAX_SIZE  = $clog2(DATA_BYTES);
    localparam logic [AW:0] MEM_BYTES = (AW+1)'(MEM_WORDS * DATA_BYTES);

    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    len_q, len_d, cnt_q, cnt_d;
    logic [2:0]    size_q, size_d;
    burst_t        burst_q, burst_d;
    logic          berr_q, berr_d;
    logic          legal;

    always_comb begin
        addr_d  = addr_q;
        len_d   = len_q;
        size_d  = size_q;
        burst_d = burst_q;
        cnt_d   = cnt_q;
        berr_d  = berr_q;
        legal   = axi4_burst_legal(addr_max_t'(addr_i), size_i, len_i, burst_t'(burst_i));
        if (load_i) begin
            addr_d = addr_i;
            len_d  = len_i;
            size_d = size_i;
            cnt_d  = '0;
            berr_d = (size_i > 3'(MAX_SIZE)) || !legal;
            // Reserved bursts and malformed wraps still step as INCR so beat counting stays sane.
            if (burst_t'(burst_i) == FIXED)             burst_d = FIXED;
            else if (burst_t'(burst_i) == WRAP && legal) burst_d = WRAP;
            else                                         burst_d = INCR;
        end else if (advance_i) begin
            addr_d = AW'(axi4_next_addr(addr_max_t'(addr_q), size_q, len_q, burst_q));
            cnt_d  = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= FIXED;
            cnt_q   <= '0;
            berr_q  <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            len_q   <= len_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            cnt_q   <= cnt_d;
            berr_q  <= berr_d;
        end
    end

    assign addr_o      = addr_q;
    assign last_o      = (cnt_q == len_q);
    assign burst_err_o = berr_q || ({1'b0, addr_q} >= MEM_BYTES);
    assign nxt_addr_o  = addr_d;
    assign nxt_last_o  = (cnt_d == len_d);
    assign nxt_err_o   = berr_d || ({1'b0, addr_d} >= MEM_BYTES);

endmodule

// File: rtl/axi4_slave_mem.sv
// AXI4 slave memory with independent single-outstanding read/write paths; B one cycle after last W,
// R one cycle after AR with back-to-back beats; all ready/valid outputs obey AXI stall rules.
module axi4_slave_mem
    import axi4_pkg::*;
#(
    parameter int DATA_BYTES      = 4,
    parameter int ADDR_BYTES      = 1,
    parameter int NUM_ID_BITS_P   = 4,
    parameter int NUM_USER_BITS_P = 4,
    parameter int MEM_WORDS       = 64
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic                         awvalid,
    output logic                         awready,
    input  logic [ADDR_BYTES*8-1:0]      awaddr,
    input  logic [7:0]                   awlen,
    input  logic [2:0]                   awsize,
    input  logic [1:0]                   awburst,
    input  logic [NUM_ID_BITS_P-1:0]     awid,
    input  logic [NUM_USER_BITS_P-1:0]   awuser,
    input  logic [3:0]                   awcache,
    input  logic [2:0]                   awprot,
    input  logic                         awlock,
    input  logic [3:0]                   awregion,
    input  logic [3:0]                   awqos,
    input  logic                         wvalid,
    output logic                         wready,
    input  logic [DATA_BYTES*8-1:0]      wdata,
    input  logic [DATA_BYTES-1:0]        wstrb,
    input  logic                         wlast,
    input  logic [NUM_USER_BITS_P-1:0]   wuser,
    output logic                         bvalid,
    input  logic                         bready,
    output logic [1:0]                   bresp,
    output logic [NUM_ID_BITS_P-1:0]     bid,
    output logic [NUM_USER_BITS_P-1:0]   buser,
    input  logic                         arvalid,
    output logic                         arready,
    input  logic [ADDR_BYTES*8-1:0]      araddr,
    input  logic [7:0]                   arlen,
    input  logic [2:0]                   arsize,
    input  logic [1:0]                   arburst,
    input  logic [NUM_ID_BITS_P-1:0]     arid,
    input  logic [NUM_USER_BITS_P-1:0]   aruser,
    input  logic [3:0]                   arcache,
    input  logic [2:0]                   arprot,
    input  logic                         arlock,
    input  logic [3:0]                   arregion,
    input  logic [3:0]                   arqos,
    output logic                         rvalid,
    input  logic                         rready,
    output logic [DATA_BYTES*8-1:0]      rdata,
    output logic [1:0]                   rresp,
    output logic                         rlast,
    output logic [NUM_ID_BITS_P-1:0]     rid,
    output logic [NUM_USER_BITS_P-1:0]   ruser
);
    localparam int AW  = ADDR_BYTES * 8;
    localparam int DW  = DATA_BYTES * 8;
    localparam int OFF = $clog2(DATA_BYTES);
    localparam int IW  = $clog2(MEM_WORDS);

    logic [DW-1:0] mem_q [MEM_WORDS];

    logic rst_done_q;
    w_state_t w_state_q, w_state_d;
    r_state_t r_state_q, r_state_d;
    logic [NUM_ID_BITS_P-1:0]   bid_q, bid_d, rid_q, rid_d;
    logic [NUM_USER_BITS_P-1:0] buser_q, buser_d, ruser_q, ruser_d;
    logic          werr_q, werr_d;
    logic          rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [DW-1:0] rdata_q, rdata_d;
    resp_t         rresp_q, rresp_d;

    logic aw_hs, w_hs, ar_hs, r_adv, r_fetch, mem_we;
    logic [AW-1:0] wag_addr, rag_nxt_addr;
    logic wag_last, wag_err, rag_nxt_last, rag_nxt_err;

    logic [AW-1:0] w_nxt_addr_unused, r_addr_unused;
    logic w_nxt_last_unused, w_nxt_err_unused, r_last_unused, r_err_unused;
    logic unused_sideband;
    assign unused_sideband = ^{awcache, awprot, awlock, awregion, awqos,
                               arcache, arprot, arlock, arregion, arqos, wuser};

    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign ar_hs   = arvalid && arready;
    assign r_adv   = (r_state_q == R_DATA) && rready && !rlast_q;
    assign r_fetch = ar_hs || r_adv;
    assign mem_we  = w_hs && !wag_err;

    axi4_burst_addr_gen #(.AW(AW), .DATA_BYTES(DATA_BYTES), .MEM_WORDS(MEM_WORDS)) u_wag (
        .clk(aclk), .rst_n(aresetn), .load_i(aw_hs), .advance_i(w_hs),
        .addr_i(awaddr), .len_i(awlen), .size_i(awsize), .burst_i(awburst),
        .addr_o(wag_addr), .last_o(wag_last), .burst_err_o(wag_err),
        .nxt_addr_o(w_nxt_addr_unused), .nxt_last_o(w_nxt_last_unused), .nxt_err_o(w_nxt_err_unused)
    );

    axi4_burst_addr_gen #(.AW(AW), .DATA_BYTES(DATA_BYTES), .MEM_WORDS(MEM_WORDS)) u_rag (
        .clk(aclk), .rst_n(aresetn), .load_i(ar_hs), .advance_i(r_adv),
        .addr_i(araddr), .len_i(arlen), .size_i(arsize), .burst_i(arburst),
        .addr_o(r_addr_unused), .last_o(r_last_unused), .burst_err_o(r_err_unused),
        .nxt_addr_o(rag_nxt_addr), .nxt_last_o(rag_nxt_last), .nxt_err_o(rag_nxt_err)
    );

    always_comb begin
        w_state_d = w_state_q;
        bid_d     = bid_q;
        buser_d   = buser_q;
        werr_d    = werr_q;
        case (w_state_q)
            W_IDLE: if (aw_hs) begin
                bid_d     = awid;
                buser_d   = awuser;
                werr_d    = 1'b0;
                w_state_d = W_DATA;
            end
            W_DATA: if (w_hs) begin
                werr_d = werr_q || wag_err || (wlast != wag_last);
                if (wag_last) w_state_d = W_RESP;
            end
            W_RESP: if (bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    // Prefetch from the lookahead address; memory is read before this edge's write lands.
    always_comb begin
        r_state_d = r_state_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        rid_d     = rid_q;
        ruser_d   = ruser_q;
        case (r_state_q)
            R_IDLE: if (ar_hs) begin
                rid_d     = arid;
                ruser_d   = aruser;
                rvalid_d  = 1'b1;
                r_state_d = R_DATA;
            end
            R_DATA: if (rready && rlast_q) begin
                rvalid_d  = 1'b0;
                rlast_d   = 1'b0;
                r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
        if (r_fetch) begin
            rdata_d = rag_nxt_err ? '0 : mem_q[IW'(rag_nxt_addr >> OFF)];
            rresp_d = rag_nxt_err ? SLVERR : OKAY;
            rlast_d = rag_nxt_last;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rst_done_q <= 1'b0;
            w_state_q  <= W_IDLE;
            bid_q      <= '0;
            buser_q    <= '0;
            werr_q     <= 1'b0;
            r_state_q  <= R_IDLE;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= OKAY;
            rlast_q    <= 1'b0;
            rid_q      <= '0;
            ruser_q    <= '0;
        end else begin
            rst_done_q <= 1'b1;
            w_state_q  <= w_state_d;
            bid_q      <= bid_d;
            buser_q    <= buser_d;
            werr_q     <= werr_d;
            r_state_q  <= r_state_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            rlast_q    <= rlast_d;
            rid_q      <= rid_d;
            ruser_q    <= ruser_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int b = 0; b < DATA_BYTES; b++) begin
                if (wstrb[b]) mem_q[IW'(wag_addr >> OFF)][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    assign awready = rst_done_q && (w_state_q == W_IDLE);
    assign wready  = (w_state_q == W_DATA);
    assign bvalid  = (w_state_q == W_RESP);
    assign bresp   = werr_q ? SLVERR : OKAY;
    assign bid     = bid_q;
    assign buser   = buser_q;
    assign arready = rst_done_q && (r_state_q == R_IDLE);
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;
    assign rid     = rid_q;
    assign ruser   = ruser_q;

endmodule

// File: tb/tb_axi4_slave_mem.sv
module tb_axi4_slave_mem;
    localparam logic [1:0] B_FIXED = 2'd0, B_INCR = 2'd1, B_WRAP = 2'd2, B_RSVD = 2'd3;

    logic        aclk = 1'b0, aresetn = 1'b0;
    logic        awvalid = 0, awready, awlock = 0;
    logic [7:0]  awaddr = 0, awlen = 0;
    logic [2:0]  awsize = 0, awprot = 0;
    logic [1:0]  awburst = 0;
    logic [3:0]  awid = 0, awuser = 0, awcache = 0, awregion = 0, awqos = 0;
    logic        wvalid = 0, wready, wlast = 0;
    logic [31:0] wdata = 0;
    logic [3:0]  wstrb = 0, wuser = 0;
    logic        bvalid, bready = 0;
    logic [1:0]  bresp;
    logic [3:0]  bid, buser;
    logic        arvalid = 0, arready, arlock = 0;
    logic [7:0]  araddr = 0, arlen = 0;
    logic [2:0]  arsize = 0, arprot = 0;
    logic [1:0]  arburst = 0;
    logic [3:0]  arid = 0, aruser = 0, arcache = 0, arregion = 0, arqos = 0;
    logic        rvalid, rready = 0, rlast;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [3:0]  rid, ruser;

    int checks = 0, failures = 0, cyc = 0;
    logic [31:0] wr_dat [16];
    logic [3:0]  wr_strb [16];
    logic [31:0] rd_dat [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    logic [3:0]  rd_id [16];
    int          rd_cyc [16];
    logic [1:0]  b_resp;
    logic [3:0]  b_id, b_user;

    axi4_slave_mem #(.DATA_BYTES(4), .ADDR_BYTES(1), .NUM_ID_BITS_P(4), .NUM_USER_BITS_P(4), .MEM_WORDS(16)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awid(awid), .awuser(awuser), .awcache(awcache), .awprot(awprot),
        .awlock(awlock), .awregion(awregion), .awqos(awqos),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wuser(wuser),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid), .buser(buser),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arid(arid), .aruser(aruser), .arcache(arcache), .arprot(arprot),
        .arlock(arlock), .arregion(arregion), .arqos(arqos),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rid(rid), .ruser(ruser)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic aw_send(input logic [7:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id, input logic [3:0] user);
        int t = 0;
        awaddr = addr; awlen = len; awsize = size; awburst = burst; awid = id; awuser = user;
        awvalid = 1'b1;
        while (!awready && t < 50) begin tick(); t++; end
        if (!awready) begin checks++; failures++; $display("FAIL aw_timeout awready=%0b required=1", awready); end
        tick();
        awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int t = 0;
        wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
        while (!wready && t < 50) begin tick(); t++; end
        if (!wready) begin checks++; failures++; $display("FAIL w_timeout wready=%0b required=1", wready); end
        tick();
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic b_recv();
        int t = 0;
        b_resp = 'x; b_id = 'x; b_user = 'x;
        bready = 1'b1;
        while (!bvalid && t < 50) begin tick(); t++; end
        if (!bvalid) begin checks++; failures++; $display("FAIL b_timeout bvalid=%0b required=1", bvalid); end
        else begin b_resp = bresp; b_id = bid; b_user = buser; end
        tick();
        bready = 1'b0;
    endtask

    // last_mode: 0 correct wlast, 1 wlast missing on final beat, 2 extra wlast on beat 0
    task automatic write_burst(input logic [7:0] addr, input logic [7:0] len, input logic [2:0] size,
                               input logic [1:0] burst, input logic [3:0] id, input int last_mode);
        aw_send(addr, len, size, burst, id, ~id);
        for (int i = 0; i <= int'(len); i++)
            w_send(wr_dat[i], wr_strb[i], ((i == int'(len)) && last_mode != 1) || (last_mode == 2 && i == 0));
        b_recv();
    endtask

    task automatic read_burst(input logic [7:0] addr, input logic [7:0] len, input logic [2:0] size,
                              input logic [1:0] burst, input logic [3:0] id);
        int t;
        for (int i = 0; i < 16; i++) begin rd_dat[i] = 'x; rd_resp[i] = 'x; rd_last[i] = 'x; rd_id[i] = 'x; end
        araddr = addr; arlen = len; arsize = size; arburst = burst; arid = id; aruser = ~id;
        arvalid = 1'b1;
        t = 0;
        while (!arready && t < 50) begin tick(); t++; end
        if (!arready) begin checks++; failures++; $display("FAIL ar_timeout arready=%0b required=1", arready); end
        tick();
        arvalid = 1'b0;
        rready = 1'b1;
        for (int i = 0; i <= int'(len); i++) begin
            t = 0;
            while (!rvalid && t < 50) begin tick(); t++; end
            if (!rvalid) begin checks++; failures++; $display("FAIL r_timeout beat=%0d rvalid=0 required=1", i); break; end
            rd_dat[i] = rdata; rd_resp[i] = rresp; rd_last[i] = rlast; rd_id[i] = rid; rd_cyc[i] = cyc;
            tick();
        end
        rready = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 16; i++) wr_strb[i] = 4'hF;
        tick(); tick();
        checks++;
        if ({awready, arready, wready, bvalid, rvalid, rlast, bresp, rresp} !== 10'b0) begin
            failures++; $display("FAIL reset_handshakes got=%b required=0", {awready, arready, wready, bvalid, rvalid, rlast, bresp, rresp});
        end
        checks++;
        if ({rdata, bid, buser, rid, ruser} !== 48'h0) begin
            failures++; $display("FAIL reset_fields got=%h required=0", {rdata, bid, buser, rid, ruser});
        end
        aresetn = 1'b1;
        #1;
        checks++;
        if (awready !== 1'b0) begin failures++; $display("FAIL awready_before_edge got=%b required=0", awready); end
        tick();
        checks++;
        if ({awready, arready} !== 2'b11) begin failures++; $display("FAIL ready_after_release got=%b required=11", {awready, arready}); end
    endtask

    task automatic test_reset_mid_burst();
        logic bseen = 1'b0;
        aw_send(8'h20, 8'd7, 3'd2, B_INCR, 4'h3, 4'h5);
        for (int i = 0; i < 3; i++) w_send(32'h100 + i, 4'hF, 1'b0);
        wdata = 32'h103; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
        #2 aresetn = 1'b0;
        #1;
        checks++;
        if ({awready, arready, wready, bvalid, rvalid} !== 5'b0) begin
            failures++; $display("FAIL midburst_reset_outputs got=%b required=0", {awready, arready, wready, bvalid, rvalid});
        end
        wvalid = 1'b0;
        tick(); tick();
        aresetn = 1'b1;
        tick();
        checks++;
        if (awready !== 1'b1) begin failures++; $display("FAIL midburst_awready got=%b required=1", awready); end
        repeat (8) begin if (bvalid) bseen = 1'b1; tick(); end
        checks++;
        if (bseen !== 1'b0) begin failures++; $display("FAIL midburst_no_bresp bvalid_seen=%b required=0", bseen); end
        wr_dat[0] = 32'hCAFEF00D;
        write_burst(8'h30, 8'd0, 3'd2, B_INCR, 4'h7, 0);
        checks++;
        if ({b_resp, b_id, b_user} !== {2'd0, 4'h7, 4'h8}) begin
            failures++; $display("FAIL midburst_next_burst got=%h required=%h", {b_resp, b_id, b_user}, {2'd0, 4'h7, 4'h8});
        end
    endtask

    task automatic test_incr();
        for (int i = 0; i < 10; i++) wr_dat[i] = $urandom;
        write_burst(8'h00, 8'd9, 3'd2, B_INCR, 4'hA, 0);
        checks++;
        if ({b_resp, b_id, b_user} !== {2'd0, 4'hA, 4'h5}) begin
            failures++; $display("FAIL incr_bresp got=%h required=%h", {b_resp, b_id, b_user}, {2'd0, 4'hA, 4'h5});
        end
        read_burst(8'h00, 8'd9, 3'd2, B_INCR, 4'h6);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (rd_dat[i] !== wr_dat[i]) begin failures++; $display("FAIL incr_rdata beat=%0d got=%h required=%h", i, rd_dat[i], wr_dat[i]); end
            checks++;
            if ({rd_resp[i], rd_last[i], rd_id[i]} !== {2'd0, (i == 9), 4'h6}) begin
                failures++; $display("FAIL incr_rresp_rlast beat=%0d got=%b required=%b", i, {rd_resp[i], rd_last[i], rd_id[i]}, {2'd0, (i == 9), 4'h6});
            end
        end
    endtask

    task automatic test_fixed();
        wr_dat[0] = 32'hDEADBEEF;
        write_burst(8'h00, 8'd0, 3'd2, B_INCR, 4'h1, 0);
        read_burst(8'h00, 8'd7, 3'd2, B_FIXED, 4'h2);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({rd_dat[i], rd_resp[i], rd_last[i]} !== {32'hDEADBEEF, 2'd0, (i == 7)}) begin
                failures++; $display("FAIL fixed_beat beat=%0d got=%h/%0d/%b required=deadbeef/0/%b", i, rd_dat[i], rd_resp[i], rd_last[i], (i == 7));
            end
        end
        checks++;
        if (rd_cyc[7] - rd_cyc[0] !== 7) begin failures++; $display("FAIL fixed_no_bubble cycles=%0d required=7", rd_cyc[7] - rd_cyc[0]); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_w [4];
        exp_w[0] = 32'd3; exp_w[1] = 32'd4; exp_w[2] = 32'd1; exp_w[3] = 32'd2;
        for (int i = 0; i < 4; i++) wr_dat[i] = 32'(i + 1);
        write_burst(8'h08, 8'd3, 3'd2, B_WRAP, 4'h4, 0);
        checks++;
        if (b_resp !== 2'd0) begin failures++; $display("FAIL wrap_bresp got=%0d required=0", b_resp); end
        read_burst(8'h00, 8'd3, 3'd2, B_INCR, 4'h4);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_dat[i] !== exp_w[i]) begin failures++; $display("FAIL wrap_layout word=%0d got=%h required=%h", i, rd_dat[i], exp_w[i]); end
        end
        for (int i = 0; i < 3; i++) wr_dat[i] = 32'h99;
        write_burst(8'h00, 8'd2, 3'd2, B_WRAP, 4'h4, 0);
        checks++;
        if (b_resp !== 2'd2) begin failures++; $display("FAIL wrap_badlen_bresp got=%0d required=2", b_resp); end
        read_burst(8'h00, 8'd3, 3'd2, B_INCR, 4'h4);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_dat[i] !== exp_w[i]) begin failures++; $display("FAIL wrap_badlen_unchanged word=%0d got=%h required=%h", i, rd_dat[i], exp_w[i]); end
        end
    endtask

    task automatic test_strobe();
        wr_dat[0] = 32'h11223344;
        write_burst(8'h10, 8'd0, 3'd2, B_INCR, 4'h9, 0);
        wr_dat[0] = 32'hAABBCCDD; wr_strb[0] = 4'b0101;
        write_burst(8'h10, 8'd0, 3'd2, B_INCR, 4'h9, 0);
        wr_strb[0] = 4'hF;
        read_burst(8'h10, 8'd0, 3'd2, B_INCR, 4'h9);
        checks++;
        if ({rd_dat[0], rd_resp[0], rd_last[0]} !== {32'h11BB33DD, 2'd0, 1'b1}) begin
            failures++; $display("FAIL strobe_merge got=%h/%0d/%b required=11bb33dd/0/1", rd_dat[0], rd_resp[0], rd_last[0]);
        end
        write_burst(8'h14, 8'd0, 3'd2, B_INCR, 4'h9, 1);
        checks++;
        if (b_resp !== 2'd2) begin failures++; $display("FAIL wlast_missing_bresp got=%0d required=2", b_resp); end
        write_burst(8'h18, 8'd1, 3'd2, B_INCR, 4'h9, 2);
        checks++;
        if (b_resp !== 2'd2) begin failures++; $display("FAIL wlast_early_bresp got=%0d required=2", b_resp); end
    endtask

    task automatic test_range();
        wr_dat[0] = 32'h600DD00D; wr_dat[1] = 32'hBAD0BAD0;
        write_burst(8'h3C, 8'd1, 3'd2, B_INCR, 4'hC, 0);
        checks++;
        if (b_resp !== 2'd2) begin failures++; $display("FAIL range_bresp got=%0d required=2", b_resp); end
        read_burst(8'h3C, 8'd1, 3'd2, B_INCR, 4'hC);
        checks++;
        if ({rd_dat[0], rd_resp[0]} !== {32'h600DD00D, 2'd0}) begin
            failures++; $display("FAIL range_beat0 got=%h/%0d required=600dd00d/0", rd_dat[0], rd_resp[0]);
        end
        checks++;
        if ({rd_dat[1], rd_resp[1], rd_last[1]} !== {32'h0, 2'd2, 1'b1}) begin
            failures++; $display("FAIL range_beat1 got=%h/%0d/%b required=0/2/1", rd_dat[1], rd_resp[1], rd_last[1]);
        end
        wr_dat[0] = 32'h77777777;
        write_burst(8'h00, 8'd0, 3'd3, B_INCR, 4'hC, 0);
        checks++;
        if (b_resp !== 2'd2) begin failures++; $display("FAIL size_err_bresp got=%0d required=2", b_resp); end
        read_burst(8'h00, 8'd0, 3'd2, B_INCR, 4'hC);
        checks++;
        if (rd_dat[0] !== 32'd3) begin failures++; $display("FAIL size_err_unchanged got=%h required=3", rd_dat[0]); end
        read_burst(8'h04, 8'd1, 3'd2, B_RSVD, 4'hC);
        checks++;
        if ({rd_dat[0], rd_resp[0], rd_dat[1], rd_resp[1]} !== {32'h0, 2'd2, 32'h0, 2'd2}) begin
            failures++; $display("FAIL rsvd_burst got=%h/%0d %h/%0d required=0/2 0/2", rd_dat[0], rd_resp[0], rd_dat[1], rd_resp[1]);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_burst();
        test_incr();
        test_fixed();
        test_wrap();
        test_strobe();
        test_range();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axi4_slave_mem.md
Name: axi4_slave_mem

Overview:
Synthesizable AXI4 full slave memory, the downstream consumer of the AXI4 master BFM and a drop-in replacement for the slave BFM on axi4_if. It accepts write and read bursts (FIXED, INCR, WRAP) into an internal byte-enabled word array. Read and write paths are fully independent, with one outstanding transaction per direction. It is the first RTL endpoint that the burst testbenches exercise.

Parameters:
DATA_BYTES, 4, data bus width in bytes (power of 2).
ADDR_BYTES, 1, address width in bytes. Address arithmetic wraps modulo 2^(ADDR_BYTES*8).
NUM_ID_BITS_P, 4, width of awid/bid/arid/rid.
NUM_USER_BITS_P, 4, width of the user sideband signals.
MEM_WORDS, 64, memory depth in DATA_BYTES words. The valid byte range is 0 to MEM_WORDS*DATA_BYTES-1.

Ports:
- aclk, in, 1, single clock; every signal is sampled on the rising edge.
- aresetn, in, 1, asynchronous active-low reset.
- awvalid/awready, in/out, 1/1, write-address handshake.
- awaddr, awlen, awsize, awburst, awid, awuser, in, ADDR_BYTES*8 / 8 / 3 / 2 / ID / USER, write-address fields.
- awcache, awprot, awlock, awregion, awqos, in, 4 / 3 / 1 / 4 / 4, accepted and ignored.
- wvalid/wready, in/out, 1/1, write-data handshake.
- wdata, wstrb, wlast, wuser, in, DATA_BYTES*8 / DATA_BYTES / 1 / USER. wuser is ignored.
- bvalid/bready, out/in, 1/1, write-response handshake.
- bresp, bid, buser, out, 2 / ID / USER.
- arvalid/arready, in/out, 1/1, read-address handshake.
- araddr, arlen, arsize, arburst, arid, aruser, in, same widths as the AW fields.
- arcache, arprot, arlock, arregion, arqos, in, ignored.
- rvalid/rready, out/in, 1/1, read-data handshake.
- rdata, rresp, rlast, rid, ruser, out, DATA_BYTES*8 / 2 / 1 / ID / USER.

Behaviour:
- Reset:
  - While aresetn is low, all outputs are 0, including awready and arready.
  - awready and arready go to 1 on the first aclk edge after reset release.
  - Reset mid-burst aborts the burst silently: no response is issued afterwards. Memory contents are not reset; the simulation initial value is 0.
- Write FSM, states W_IDLE, W_DATA, W_RESP:
  - W_IDLE: awready=1. On the AW handshake, latch addr/len/size/burst/id/user, clear the beat count and error flag, then go to W_DATA. awready drops the following cycle.
  - W_DATA: wready=1. Each W handshake writes the bytes of wdata selected by wstrb into mem[addr/DATA_BYTES], then advances the address and beat count.
  - After the beat where count==awlen, go to W_RESP. The burst is always exactly awlen+1 beats.
  - W_RESP: bvalid=1, bid=latched id, buser=latched awuser, bresp = SLVERR(2) if the error flag is set, else OKAY(0). On bready, go to W_IDLE.
  - Latency: bvalid rises the cycle after the last W handshake. awready returns the cycle after the B handshake.
- Read FSM, states R_IDLE, R_DATA:
  - R_IDLE: arready=1. On the AR handshake, latch the fields and load rdata/rresp for beat 0. rvalid=1 on the next cycle.
  - R_DATA: on each R handshake, load the next beat's data into rdata in the same edge, so back-to-back beats have no bubble.
  - rlast=1 only when count==arlen. After the rlast handshake, go to R_IDLE with rvalid=0 and arready=1 on the next cycle.
  - rid and ruser hold the latched arid and aruser for the whole burst.
  - rdata, rresp and rlast stay stable while rvalid && !rready.
- Address generation, applied per beat with S = 2^size:
  - FIXED: address unchanged.
  - INCR: next = (addr aligned down to S) + S.
  - WRAP: B = (len+1)*S; next = (addr & ~(B-1)) | ((addr+S) & (B-1)).
- Error conditions, all reported as SLVERR:
  - size > log2(DATA_BYTES): the whole burst errors.
  - burst = 2'b11: the whole burst errors; beats are still counted as INCR.
  - WRAP with len not in {1,3,7,15}, or a start address not aligned to S: the whole burst errors, addresses are generated as INCR.
  - A beat address outside the memory range errors that beat only.
  - wlast mismatch (wlast=1 on a non-final beat, or wlast=0 on the final beat) sets the write error flag.
- Error consequences:
  - Writes: an errored beat leaves memory unchanged. bresp is SLVERR if any beat errored.
  - Reads: each beat carries its own rresp; an errored beat returns rdata=0.
- Narrow transfers: the slave does not enforce lane placement. wstrb is applied exactly as driven, and reads return the full word.
- Read/write collision: a read beat loaded on the same edge as a write to the same word returns the old data.
- The 4 KB boundary is not checked.

Decomposition:
- Package axi4_pkg:
  - burst_t enum: FIXED=0, INCR=1, WRAP=2, RSVD=3.
  - resp_t enum: OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3.
  - Function axi4_next_addr(addr, size, len, burst).
  - Function axi4_burst_legal(addr, size, len, burst).
- One sub-module, axi4_burst_addr_gen, instantiated twice (write and read):
  - Holds the current address and beat count.
  - Inputs: load, advance.
  - Outputs: addr, last, burst_err.

Test Plan:
1. Reset mid-burst: drop aresetn during W beat 3 → all outputs 0 immediately. After release, awready=1, bvalid never asserts, and the next burst completes normally.
2. INCR, size 2, write of 10 random words at 0x00 → bresp=0. INCR read at 0x00, arlen=9 → 10 beats matching the written data, rlast only on beat 10, rresp=0 on every beat.
3. FIXED read at 0x00, arlen=7, after mem[0]=0xDEADBEEF → 8 beats of 0xDEADBEEF, no idle cycles while rready=1.
4. WRAP write, len 3, size 2, at 0x08 with data 1,2,3,4 → words 0x08=1, 0x0C=2, 0x00=3, 0x04=4. WRAP with len=2 → bresp=2 and no memory change.
5. Byte strobes: mem[0x10]=0x11223344, then write 0xAABBCCDD with wstrb=0101 → reading back gives 0x11BB33DD. Separately, wlast=0 on the final beat → bresp=2.
6. Out of range, MEM_WORDS=16: INCR write at 0x3C, len 1 → bresp=2 and 0x3C written. Read of the same burst → rresp 0 then 2, second rdata=0.
